// File: rtl/uart_tx_frame_pkg.sv
// Shared constants for the UART transmit framer.
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - Parity type selection (PAR_EVEN / PAR_ODD)
//   - Serial line levels for idle, start and stop bits
package uart_tx_frame_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register plus bit counter for the UART framer.
// Ports:
//   i_clk     bit-rate clock
//   i_rst     synchronous active-high reset (shift register and counter to 0)
//   i_load    load i_data and clear the counter (takes priority over i_shift)
//   i_shift   shift right by one and advance the counter
//   i_data    payload to load
//   o_bit     current LSB of the shift register (next bit to transmit)
//   o_done    counter is on the last payload bit
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_bit,
    output logic                  o_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign o_bit  = shift_q[0];
    assign o_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_load) begin
            shift_d = i_data;
            cnt_d   = '0;
        end else if (i_shift) begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            // Wrap to 0 after the last bit so the counter is clean for the next frame.
            cnt_d   = o_done ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer, one serial bit per i_clk (the divided bit-rate clock).
// Frame: start (0), DATA_WIDTH payload bits LSB first, optional parity, stop (1).
// Ports:
//   i_clk         bit-rate clock
//   i_rst         synchronous active-high reset; aborts any frame in progress
//   i_data        payload, latched on acceptance
//   i_data_valid  send request
//   i_par_en      1 = append parity bit, latched on acceptance
//   i_par_typ     0 = even, 1 = odd, latched on acceptance
//   o_tx          registered serial line, idles high
//   o_busy        registered, high while a frame is on the line
//
// Handshake: a request is accepted on any clock edge where i_data_valid=1 and
// the FSM is in IDLE or STOP; there is no ready output, so callers wait for
// o_busy=0 or hold valid through the STOP cycle for a gapless next frame.
// Requests in START/DATA/PARITY are dropped, never queued.
//
// o_tx and o_busy are computed from the current state and registered, so the
// line lags the FSM by one clock: valid at edge N -> start bit after edge N+1.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx,
    output logic                  o_busy
);

    logic [2:0] state_q, state_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic       accept;
    logic       ser_shift;
    logic       ser_bit;
    logic       ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (accept),
        .i_shift (ser_shift),
        .i_data  (i_data),
        .o_bit   (ser_bit),
        .o_done  (ser_done)
    );

    // Next-state logic and acceptance.
    always_comb begin
        state_d   = state_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        accept    = 1'b0;
        ser_shift = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_data_valid) accept = 1'b1;
            end
            ST_START: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                ser_shift = 1'b1;
                if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (i_data_valid) accept = 1'b1;
                else              state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d   = ST_START;
            par_en_d  = i_par_en;
            // Even parity is the XOR of the payload; odd inverts it.
            par_bit_d = (^i_data) ^ (i_par_typ == PAR_ODD);
        end
    end

    // Output mux: line level for the bit belonging to the current state.
    always_comb begin
        tx_d   = IDLE_LVL;
        busy_d = (state_q != ST_IDLE);
        case (state_q)
            ST_START:  tx_d = START_LVL;
            ST_DATA:   tx_d = ser_bit;
            ST_PARITY: tx_d = par_bit_q;
            ST_STOP:   tx_d = STOP_LVL;
            default:   tx_d = IDLE_LVL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= IDLE_LVL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule
